// File: rtl/store_buffer.sv
// In-order store buffer: allocates entries at dispatch, captures LSU address/data,
// commits on ROB retire, drains committed stores to memory in order and forwards to loads.
module store_buffer #(
    parameter int SB_DEPTH = 32,
    parameter int SB_SIZE  = 5,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Flush,
    input  logic               Alloc1_V,
    input  logic               Alloc2_V,
    output logic [SB_SIZE-1:0] SB_Addr1,
    output logic [SB_SIZE-1:0] SB_Addr2,
    output logic               SB_stall,
    input  logic               LSU_St_V,
    input  logic [SB_SIZE-1:0] LSU_St_Idx,
    input  logic [ADDR_W-1:0]  LSU_St_Addr,
    input  logic [DATA_W-1:0]  LSU_St_Data,
    input  logic               ROB_Retire1_SB_V,
    input  logic               ROB_Retire2_SB_V,
    input  logic [SB_SIZE-1:0] ROB_Retire1_SB_Addr,
    input  logic [SB_SIZE-1:0] ROB_Retire2_SB_Addr,
    output logic               Mem_Wr_V,
    output logic [ADDR_W-1:0]  Mem_Wr_Addr,
    output logic [DATA_W-1:0]  Mem_Wr_Data,
    input  logic               Mem_Wr_Ack,
    input  logic [ADDR_W-1:0]  Ld_Addr,
    output logic               Ld_Fwd_Hit,
    output logic [DATA_W-1:0]  Ld_Fwd_Data
);

    typedef enum logic [1:0] {S_FREE, S_ALLOC, S_READY, S_COMMIT} st_t;

    st_t                            st_q  [SB_DEPTH];
    st_t                            st_nx [SB_DEPTH];
    logic [SB_DEPTH-1:0]            rdy_q, rdy_nx, wr_en;
    logic [SB_DEPTH-1:0][ADDR_W-1:0] addr_q;
    logic [SB_DEPTH-1:0][DATA_W-1:0] data_q;

    logic [SB_SIZE:0]   head_q, tail_q, head_nx, tail_nx;
    logic [SB_SIZE:0]   cnt, free_cnt, ncommit;
    logic [SB_SIZE-1:0] head_idx, tail_idx, fidx;
    logic               a1, a2, drain;

    assign head_idx = head_q[SB_SIZE-1:0];
    assign tail_idx = tail_q[SB_SIZE-1:0];
    assign cnt      = tail_q - head_q;
    assign free_cnt = (SB_SIZE+1)'(SB_DEPTH) - cnt;
    assign SB_stall = free_cnt < (SB_SIZE+1)'(2);

    assign SB_Addr1 = tail_idx;
    assign SB_Addr2 = tail_idx + SB_SIZE'(Alloc1_V);

    // Flush and stall both suppress allocation; indices are still presented.
    assign a1 = Alloc1_V & ~SB_stall & ~Flush;
    assign a2 = Alloc2_V & ~SB_stall & ~Flush;

    assign Mem_Wr_V    = (cnt != '0) && (st_q[head_idx] == S_COMMIT) && rdy_q[head_idx];
    assign Mem_Wr_Addr = addr_q[head_idx];
    assign Mem_Wr_Data = data_q[head_idx];
    assign drain       = Mem_Wr_V & Mem_Wr_Ack;

    always_comb begin
        ncommit = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            st_nx[i]  = st_q[i];
            rdy_nx[i] = rdy_q[i];
            wr_en[i]  = LSU_St_V && (LSU_St_Idx == SB_SIZE'(i)) &&
                        (st_q[i] == S_ALLOC || st_q[i] == S_COMMIT);
            if (wr_en[i]) begin
                rdy_nx[i] = 1'b1;
                if (st_q[i] == S_ALLOC) st_nx[i] = S_READY;
            end
            // Retire requests to free or already-committed entries are dropped.
            if (((ROB_Retire1_SB_V && ROB_Retire1_SB_Addr == SB_SIZE'(i)) ||
                 (ROB_Retire2_SB_V && ROB_Retire2_SB_Addr == SB_SIZE'(i))) &&
                (st_q[i] == S_ALLOC || st_q[i] == S_READY))
                st_nx[i] = S_COMMIT;
            if (drain && head_idx == SB_SIZE'(i)) begin
                st_nx[i]  = S_FREE;
                rdy_nx[i] = 1'b0;
            end
            if (Flush && st_nx[i] != S_COMMIT) begin
                st_nx[i]  = S_FREE;
                rdy_nx[i] = 1'b0;
            end
            if ((a1 && tail_idx == SB_SIZE'(i)) || (a2 && SB_Addr2 == SB_SIZE'(i))) begin
                st_nx[i]  = S_ALLOC;
                rdy_nx[i] = 1'b0;
            end
        end
        for (int i = 0; i < SB_DEPTH; i++)
            if (st_nx[i] == S_COMMIT) ncommit = ncommit + 1'b1;
    end

    // Committed entries are contiguous from head, so a flush rewinds tail to just past them.
    assign head_nx = head_q + (SB_SIZE+1)'(drain);
    assign tail_nx = Flush ? head_nx + ncommit
                           : tail_q + (SB_SIZE+1)'(a1) + (SB_SIZE+1)'(a2);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head_q <= '0;
            tail_q <= '0;
            rdy_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) st_q[i] <= S_FREE;
        end else begin
            head_q <= head_nx;
            tail_q <= tail_nx;
            rdy_q  <= rdy_nx;
            for (int i = 0; i < SB_DEPTH; i++) begin
                st_q[i] <= st_nx[i];
                if (wr_en[i]) begin
                    addr_q[i] <= LSU_St_Addr;
                    data_q[i] <= LSU_St_Data;
                end
            end
        end
    end

    // Scan oldest to youngest so the last match (nearest tail-1) wins.
    always_comb begin
        Ld_Fwd_Hit  = 1'b0;
        Ld_Fwd_Data = '0;
        fidx        = '0;
        for (int k = 0; k < SB_DEPTH; k++) begin
            fidx = head_idx + SB_SIZE'(k);
            if (st_q[fidx] != S_FREE && rdy_q[fidx] && addr_q[fidx] == Ld_Addr) begin
                Ld_Fwd_Hit  = 1'b1;
                Ld_Fwd_Data = data_q[fidx];
            end
        end
    end

endmodule
